reorder_buffer_mwb: RTL and testbench

//  Parametrised in-order-commit reorder buffer with NUM_WB write-back channels (ALU/RS, LSB, ...).

---
 rtl/reorder_buffer_mwb.sv | 212 +++++++++++++++++++++
 tb/tb_reorder_buffer_mwb.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mwb.sv
// ---------------------------------------------------------------------------
// reorder_buffer_mwb
//   In-order-commit reorder buffer with NUM_WB write-back channels.
//   Instructions are allocated at the tail on dispatch. Execution units mark
//   them ready out of order through the write-back channels. They retire from
//   the head one per cycle. A mispredicted branch at the head empties the
//   buffer and raises a one-cycle flush with the corrected fetch pc.
//
// Ports
//   clk_in, rst_in      clock / asynchronous active-high reset
//   rdy_in              0 freezes every register (pulses hold their value)
//   dec_*               dispatch request, allocated id, full flag
//   wb_*                NUM_WB packed write-back channels (id, data, taken)
//   q{j,k}_*            combinational operand lookup with write-back forwarding
//   commit_*            registered one-cycle commit record
//   head_rob_id         oldest entry, used by the LSB for store ordering
//   rob_empty           no entries in flight
//   flush, flush_pc     registered one-cycle mispredict redirect
// ---------------------------------------------------------------------------
module reorder_buffer_mwb #(
    parameter int ROB_WIDTH = 4,
    parameter int NUM_WB    = 2,
    parameter int REG_WIDTH = 5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          dec_valid,
    output logic                          dec_full,
    output logic [ROB_WIDTH-1:0]          dec_rob_id,
    input  logic                          dec_ready,
    input  logic [31:0]                   dec_res,
    input  logic [1:0]                    dec_type,
    input  logic [REG_WIDTH-1:0]          dec_dest,
    input  logic [31:0]                   dec_next_addr,
    input  logic [31:0]                   dec_jump_addr,
    input  logic                          dec_predict,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*ROB_WIDTH-1:0]   wb_rob_id,
    input  logic [NUM_WB*32-1:0]          wb_data,
    input  logic [NUM_WB-1:0]             wb_taken,
    input  logic [ROB_WIDTH-1:0]          qj_rob_id,
    output logic                          qj_ready,
    output logic [31:0]                   qj_data,
    input  logic [ROB_WIDTH-1:0]          qk_rob_id,
    output logic                          qk_ready,
    output logic [31:0]                   qk_data,
    output logic                          commit_valid,
    output logic [REG_WIDTH-1:0]          commit_reg_id,
    output logic [31:0]                   commit_data,
    output logic [ROB_WIDTH-1:0]          commit_rob_id,
    output logic                          commit_store,
    output logic [ROB_WIDTH-1:0]          head_rob_id,
    output logic                          rob_empty,
    output logic                          flush,
    output logic [31:0]                   flush_pc
);
    localparam int DEPTH = 2 ** ROB_WIDTH;
    localparam logic [1:0] TYPE_REG    = 2'd0;
    localparam logic [1:0] TYPE_STORE  = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;

    // Entry storage is kept in flops: lookups must be combinational.
    logic [DEPTH-1:0]                present_reg, ready_reg, taken_reg, predict_reg;
    logic [DEPTH-1:0][31:0]          res_reg, next_addr_reg, jump_addr_reg;
    logic [DEPTH-1:0][1:0]           type_reg;
    logic [DEPTH-1:0][REG_WIDTH-1:0] dest_reg;
    logic [ROB_WIDTH-1:0]            head_reg, tail_reg;
    logic [ROB_WIDTH:0]              count_reg;

    // Per-entry write-back match; the lowest channel index wins on collision.
    logic [DEPTH-1:0]       wb_hit, wb_hit_taken;
    logic [DEPTH-1:0][31:0] wb_hit_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wb_match
        logic        hit;
        logic        hit_taken;
        logic [31:0] hit_data;
        always_comb begin
            hit       = 1'b0;
            hit_taken = 1'b0;
            hit_data  = '0;
            for (int c = NUM_WB - 1; c >= 0; c--) begin
                if (wb_valid[c] && wb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(gi)) begin
                    hit       = 1'b1;
                    hit_taken = wb_taken[c];
                    hit_data  = wb_data[c*32 +: 32];
                end
            end
        end
        assign wb_hit[gi]       = hit;
        assign wb_hit_taken[gi] = hit_taken;
        assign wb_hit_data[gi]  = hit_data;
    end

    // Operand lookup: stored result first, else forward a write-back landing
    // this cycle. Only entries currently in flight can answer.
    logic [1:0][ROB_WIDTH-1:0] q_id;
    logic [1:0]                q_ready;
    logic [1:0][31:0]          q_data;
    assign q_id[0] = qj_rob_id;
    assign q_id[1] = qk_rob_id;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
        logic        rdy;
        logic [31:0] val;
        always_comb begin
            rdy = 1'b0;
            val = '0;
            if (present_reg[q_id[gi]]) begin
                if (ready_reg[q_id[gi]]) begin
                    rdy = 1'b1;
                    val = res_reg[q_id[gi]];
                end else if (wb_hit[q_id[gi]]) begin
                    rdy = 1'b1;
                    val = wb_hit_data[q_id[gi]];
                end
            end
        end
        assign q_ready[gi] = rdy;
        assign q_data[gi]  = val;
    end

    assign qj_ready = q_ready[0];
    assign qj_data  = q_data[0];
    assign qk_ready = q_ready[1];
    assign qk_data  = q_data[1];

    logic do_commit, mispredict, do_dispatch;
    assign do_commit   = present_reg[head_reg] && ready_reg[head_reg];
    assign mispredict  = do_commit && (type_reg[head_reg] == TYPE_BRANCH) &&
                         (taken_reg[head_reg] != predict_reg[head_reg]);
    // A slot freed by this edge's commit is not reusable until the next cycle.
    assign do_dispatch = dec_valid && !dec_full && !mispredict;

    assign dec_full    = (count_reg == (ROB_WIDTH+1)'(DEPTH));
    assign rob_empty   = (count_reg == '0);
    assign dec_rob_id  = tail_reg;
    assign head_rob_id = head_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            present_reg   <= '0;
            ready_reg     <= '0;
            taken_reg     <= '0;
            predict_reg   <= '0;
            res_reg       <= '0;
            next_addr_reg <= '0;
            jump_addr_reg <= '0;
            type_reg      <= '0;
            dest_reg      <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            commit_valid  <= 1'b0;
            commit_reg_id <= '0;
            commit_data   <= '0;
            commit_rob_id <= '0;
            commit_store  <= 1'b0;
            flush         <= 1'b0;
            flush_pc      <= '0;
        end else if (rdy_in) begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;

            for (int i = 0; i < DEPTH; i++) begin
                if (present_reg[i] && wb_hit[i]) begin
                    ready_reg[i] <= 1'b1;
                    res_reg[i]   <= wb_hit_data[i];
                    taken_reg[i] <= wb_hit_taken[i];
                end
            end

            if (do_dispatch) begin
                present_reg[tail_reg]   <= 1'b1;
                ready_reg[tail_reg]     <= dec_ready;
                res_reg[tail_reg]       <= dec_res;
                taken_reg[tail_reg]     <= 1'b0;
                predict_reg[tail_reg]   <= dec_predict;
                type_reg[tail_reg]      <= dec_type;
                dest_reg[tail_reg]      <= dec_dest;
                next_addr_reg[tail_reg] <= dec_next_addr;
                jump_addr_reg[tail_reg] <= dec_jump_addr;
                tail_reg                <= tail_reg + 1'b1;
            end

            if (do_commit) begin
                commit_valid          <= 1'b1;
                commit_rob_id         <= head_reg;
                commit_data           <= res_reg[head_reg];
                commit_reg_id         <= (type_reg[head_reg] == TYPE_REG) ? dest_reg[head_reg] : '0;
                commit_store          <= (type_reg[head_reg] == TYPE_STORE);
                present_reg[head_reg] <= 1'b0;
                head_reg              <= head_reg + 1'b1;
            end

            count_reg <= count_reg + {{ROB_WIDTH{1'b0}}, do_dispatch}
                                   - {{ROB_WIDTH{1'b0}}, do_commit};

            // Later assignments override the normal updates above.
            if (mispredict) begin
                present_reg <= '0;
                head_reg    <= '0;
                tail_reg    <= '0;
                count_reg   <= '0;
                flush       <= 1'b1;
                flush_pc    <= taken_reg[head_reg] ? jump_addr_reg[head_reg]
                                                   : next_addr_reg[head_reg];
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mwb.sv
module tb_reorder_buffer_mwb;
    logic        clk_in = 1'b0, rst_in, rdy_in;
    logic        dec_valid, dec_full, dec_ready, dec_predict;
    logic [3:0]  dec_rob_id;
    logic [31:0] dec_res, dec_next_addr, dec_jump_addr;
    logic [1:0]  dec_type;
    logic [4:0]  dec_dest;
    logic [1:0]  wb_valid, wb_taken;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_data;
    logic [3:0]  qj_rob_id, qk_rob_id;
    logic        qj_ready, qk_ready;
    logic [31:0] qj_data, qk_data;
    logic        commit_valid, commit_store, rob_empty, flush;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_data, flush_pc;
    logic [3:0]  commit_rob_id, head_rob_id;

    reorder_buffer_mwb #(.ROB_WIDTH(4), .NUM_WB(2), .REG_WIDTH(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dec_valid(dec_valid), .dec_full(dec_full), .dec_rob_id(dec_rob_id),
        .dec_ready(dec_ready), .dec_res(dec_res), .dec_type(dec_type), .dec_dest(dec_dest),
        .dec_next_addr(dec_next_addr), .dec_jump_addr(dec_jump_addr), .dec_predict(dec_predict),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_data(wb_data), .wb_taken(wb_taken),
        .qj_rob_id(qj_rob_id), .qj_ready(qj_ready), .qj_data(qj_data),
        .qk_rob_id(qk_rob_id), .qk_ready(qk_ready), .qk_data(qk_data),
        .commit_valid(commit_valid), .commit_reg_id(commit_reg_id), .commit_data(commit_data),
        .commit_rob_id(commit_rob_id), .commit_store(commit_store), .head_rob_id(head_rob_id),
        .rob_empty(rob_empty), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // Reference model: the buffer is an ordered list of in-flight instructions.
    typedef struct {
        logic [3:0]  id;
        logic [1:0]  typ;
        logic [4:0]  dest;
        logic        rdy;
        logic [31:0] res;
        logic        taken;
        logic        pred;
        logic [31:0] nxt;
        logic [31:0] jmp;
    } ent_t;
    ent_t q[$];
    int   m_tail = 0;
    logic        e_cv, e_store, e_flush;
    logic [4:0]  e_reg;
    logic [31:0] e_data, e_fpc;
    logic [3:0]  e_id;
    logic [3:0]  log_id[$];
    logic [31:0] log_data[$];

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        e_cv = 0; e_store = 0; e_flush = 0; e_reg = 0; e_data = 0; e_fpc = 0; e_id = 0;
    endtask

    task automatic m_lookup(input logic [3:0] id, output logic r, output logic [31:0] d);
        r = 0; d = 0;
        foreach (q[k]) begin
            if (q[k].id == id) begin
                if (q[k].rdy) begin
                    r = 1; d = q[k].res;
                end else begin
                    for (int c = 1; c >= 0; c--)
                        if (wb_valid[c] && wb_rob_id[c*4 +: 4] == id) begin
                            r = 1; d = wb_data[c*32 +: 32];
                        end
                end
            end
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        ent_t f;
        ent_t n;
        bit   do_commit = 0;
        bit   mis = 0;
        if (!rdy_in) return;
        e_cv = 0; e_flush = 0;
        if (q.size() > 0 && q[0].rdy) begin
            do_commit = 1;
            f = q[0];
            mis = (f.typ == 2) && (f.taken != f.pred);
        end
        for (int c = 1; c >= 0; c--)
            if (wb_valid[c])
                foreach (q[k])
                    if (q[k].id == wb_rob_id[c*4 +: 4]) begin
                        q[k].rdy = 1; q[k].res = wb_data[c*32 +: 32]; q[k].taken = wb_taken[c];
                    end
        if (dec_valid && q.size() < 16) begin
            n.id = 4'(m_tail); n.typ = dec_type; n.dest = dec_dest; n.rdy = dec_ready;
            n.res = dec_res; n.taken = 0; n.pred = dec_predict;
            n.nxt = dec_next_addr; n.jmp = dec_jump_addr;
            q.push_back(n);
            m_tail = (m_tail + 1) % 16;
        end
        if (do_commit) begin
            void'(q.pop_front());
            e_cv = 1; e_id = f.id; e_data = f.res;
            e_reg = (f.typ == 0) ? f.dest : 5'd0;
            e_store = (f.typ == 1);
            if (mis) begin
                q.delete();
                m_tail = 0;
                e_flush = 1;
                e_fpc = f.taken ? f.jmp : f.nxt;
            end
        end
    endtask

    // One clock: check lookups before the edge, outputs after it.
    task automatic step();
        logic        er, r;
        logic [31:0] ed;
        logic [3:0]  eh;
        #1;
        m_lookup(qj_rob_id, er, ed);
        checks++;
        if (qj_ready !== er || qj_data !== ed) begin
            failures++;
            $display("FAIL qj_lookup id=%0d: got rdy=%0b data=%h expected rdy=%0b data=%h", qj_rob_id, qj_ready, qj_data, er, ed);
        end
        m_lookup(qk_rob_id, er, ed);
        checks++;
        if (qk_ready !== er || qk_data !== ed) begin
            failures++;
            $display("FAIL qk_lookup id=%0d: got rdy=%0b data=%h expected rdy=%0b data=%h", qk_rob_id, qk_ready, qk_data, er, ed);
        end
        r = rdy_in;
        model_edge();
        @(posedge clk_in);
        #1;
        checks++;
        if (commit_valid !== e_cv) begin
            failures++;
            $display("FAIL commit_valid: got %0b expected %0b", commit_valid, e_cv);
        end
        if (e_cv) begin
            checks++;
            if (commit_rob_id !== e_id || commit_reg_id !== e_reg || commit_data !== e_data || commit_store !== e_store) begin
                failures++;
                $display("FAIL commit_record: got id=%0d reg=%0d data=%h st=%0b expected id=%0d reg=%0d data=%h st=%0b",
                         commit_rob_id, commit_reg_id, commit_data, commit_store, e_id, e_reg, e_data, e_store);
            end
        end
        checks++;
        if (flush !== e_flush || (e_flush && flush_pc !== e_fpc)) begin
            failures++;
            $display("FAIL flush: got %0b pc=%h expected %0b pc=%h", flush, flush_pc, e_flush, e_fpc);
        end
        eh = (q.size() > 0) ? q[0].id : 4'(m_tail);
        checks++;
        if (dec_full !== (q.size() == 16) || rob_empty !== (q.size() == 0) ||
            dec_rob_id !== 4'(m_tail) || head_rob_id !== eh) begin
            failures++;
            $display("FAIL occupancy: got full=%0b empty=%0b tail=%0d head=%0d expected full=%0b empty=%0b tail=%0d head=%0d",
                     dec_full, rob_empty, dec_rob_id, head_rob_id, q.size() == 16, q.size() == 0, m_tail, eh);
        end
        if (r && commit_valid) begin
            log_id.push_back(commit_rob_id);
            log_data.push_back(commit_data);
        end
    endtask

    task automatic set_idle();
        rdy_in = 1; dec_valid = 0; dec_ready = 0; dec_res = 0; dec_type = 0; dec_dest = 0;
        dec_next_addr = 0; dec_jump_addr = 0; dec_predict = 0;
        wb_valid = 0; wb_rob_id = 0; wb_data = 0; wb_taken = 0; qj_rob_id = 0; qk_rob_id = 0;
    endtask

    task automatic drain();
        int n = 0;
        int c;
        set_idle();
        while ((q.size() != 0 || rob_empty !== 1'b1) && n < 64) begin
            wb_valid = 0;
            c = 0;
            foreach (q[k])
                if (!q[k].rdy && c < 2) begin
                    wb_valid[c] = 1; wb_rob_id[c*4 +: 4] = q[k].id;
                    wb_data[c*32 +: 32] = $urandom; wb_taken[c] = q[k].pred;
                    c++;
                end
            step();
            n++;
        end
        checks++;
        if (rob_empty !== 1'b1 || q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got empty=%0b model_size=%0d expected empty=1 size=0", rob_empty, q.size());
        end
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst_in = 1;
        model_reset();
        #12;
        checks++;
        if ({commit_valid, commit_reg_id, commit_data, commit_rob_id, commit_store, flush, flush_pc} !== '0) begin
            failures++;
            $display("FAIL reset_regs: got cv=%0b reg=%0d data=%h id=%0d st=%0b fl=%0b pc=%h expected all 0",
                     commit_valid, commit_reg_id, commit_data, commit_rob_id, commit_store, flush, flush_pc);
        end
        checks++;
        if (dec_full !== 0 || rob_empty !== 1 || dec_rob_id !== 0 || head_rob_id !== 0 || qj_ready !== 0) begin
            failures++;
            $display("FAIL reset_flags: got full=%0b empty=%0b tail=%0d head=%0d qj=%0b expected 0 1 0 0 0",
                     dec_full, rob_empty, dec_rob_id, head_rob_id, qj_ready);
        end
        @(negedge clk_in) rst_in = 0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 17; i++) begin
            set_idle();
            dec_valid = 1; dec_res = $urandom; dec_dest = 5'($urandom_range(31));
            dec_type = 0; qj_rob_id = 4'(i);
            step();
            if (i == 15) begin
                checks++;
                if (dec_full !== 1) begin
                    failures++;
                    $display("FAIL full_after_16: got %0b expected 1", dec_full);
                end
            end
        end
        checks++;
        if (dec_full !== 1 || dec_rob_id !== 0) begin
            failures++;
            $display("FAIL dispatch_17_ignored: got full=%0b tail=%0d expected full=1 tail=0", dec_full, dec_rob_id);
        end
        drain();
    endtask

    task automatic test_out_of_order();
        log_id.delete(); log_data.delete();
        for (int i = 0; i < 3; i++) begin
            set_idle(); dec_valid = 1; dec_dest = 5'(i + 1); step();
        end
        set_idle(); wb_valid = 2'b01; wb_rob_id[3:0] = 4'd2; wb_data[31:0] = 32'hA2A2; step();
        set_idle(); wb_valid = 2'b10; wb_rob_id[7:4] = 4'd0; wb_data[63:32] = 32'hB0B0; step();
        set_idle(); wb_valid = 2'b01; wb_rob_id[3:0] = 4'd1; wb_data[31:0] = 32'hC1C1; step();
        set_idle();
        repeat (4) step();
        checks++;
        if (log_id.size() != 3) begin
            failures++;
            $display("FAIL ooo_commit_count: got %0d expected 3", log_id.size());
        end else begin
            checks++;
            if (log_id[0] !== 0 || log_id[1] !== 1 || log_id[2] !== 2) begin
                failures++;
                $display("FAIL ooo_order: got %0d,%0d,%0d expected 0,1,2", log_id[0], log_id[1], log_id[2]);
            end
            checks++;
            if (log_data[0] !== 32'hB0B0 || log_data[1] !== 32'hC1C1 || log_data[2] !== 32'hA2A2) begin
                failures++;
                $display("FAIL ooo_data: got %h,%h,%h expected b0b0,c1c1,a2a2", log_data[0], log_data[1], log_data[2]);
            end
        end
    endtask

    task automatic test_mispredict();
        set_idle();
        checks++;
        if (dec_rob_id !== 4'd3) begin
            failures++;
            $display("FAIL branch_id: got %0d expected 3", dec_rob_id);
        end
        dec_valid = 1; dec_type = 2; dec_predict = 0;
        dec_next_addr = 32'h2004; dec_jump_addr = 32'h1000;
        step();
        set_idle(); wb_valid = 2'b01; wb_rob_id[3:0] = 4'd3; wb_taken = 2'b01; step();
        set_idle(); dec_valid = 1; dec_ready = 1; dec_dest = 5'd9; step();
        checks++;
        if (flush !== 1 || flush_pc !== 32'h1000 || rob_empty !== 1 || dec_rob_id !== 0 ||
            commit_valid !== 1 || commit_reg_id !== 0) begin
            failures++;
            $display("FAIL mispredict: got fl=%0b pc=%h empty=%0b tail=%0d cv=%0b reg=%0d expected 1 1000 1 0 1 0",
                     flush, flush_pc, rob_empty, dec_rob_id, commit_valid, commit_reg_id);
        end
        set_idle(); step();
        checks++;
        if (flush !== 0) begin
            failures++;
            $display("FAIL flush_one_cycle: got %0b expected 0", flush);
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 6; i++) begin
            set_idle(); dec_valid = 1; dec_dest = 5'(i); step();
        end
        set_idle();
        wb_valid = 2'b10; wb_rob_id[7:4] = 4'd5; wb_data[63:32] = 32'hDEAD; qj_rob_id = 4'd5; qk_rob_id = 4'd4;
        #1;
        checks++;
        if (qj_ready !== 1 || qj_data !== 32'hDEAD || qk_ready !== 0 || qk_data !== 0) begin
            failures++;
            $display("FAIL forward_ch1: got qj=%0b/%h qk=%0b/%h expected 1/dead 0/0", qj_ready, qj_data, qk_ready, qk_data);
        end
        step();
        set_idle();
        wb_valid = 2'b11; wb_rob_id = {4'd4, 4'd4}; wb_data = {32'h2222, 32'h1111}; qk_rob_id = 4'd4;
        #1;
        checks++;
        if (qk_ready !== 1 || qk_data !== 32'h1111) begin
            failures++;
            $display("FAIL forward_collision: got %0b/%h expected 1/1111", qk_ready, qk_data);
        end
        step();
        drain();
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        bit saw_wrap = 0;
        log_id.delete(); log_data.delete();
        for (int i = 0; i < 40; i++) begin
            set_idle();
            dec_valid = 1; dec_ready = 1; dec_res = $urandom; dec_dest = 5'($urandom_range(31));
            prev = dec_rob_id;
            step();
            if (prev == 4'd15 && dec_rob_id == 4'd0) saw_wrap = 1;
            checks++;
            if (dec_full !== 0) begin
                failures++;
                $display("FAIL wrap_full: got %0b expected 0", dec_full);
            end
        end
        checks++;
        if (!saw_wrap) begin
            failures++;
            $display("FAIL wrap_seen: got 0 expected 1");
        end
        for (int i = 1; i < log_id.size(); i++) begin
            checks++;
            if (log_id[i] !== 4'(log_id[i-1] + 4'd1)) begin
                failures++;
                $display("FAIL wrap_order: got %0d after %0d expected %0d", log_id[i], log_id[i-1], 4'(log_id[i-1] + 4'd1));
            end
        end
        drain();
    endtask

    task automatic test_rdy_hold();
        logic [3:0] h, t, id0;
        logic       cv;
        for (int i = 0; i < 2; i++) begin
            set_idle(); dec_valid = 1; dec_dest = 5'(i + 3); step();
        end
        set_idle();
        id0 = q[0].id;
        wb_valid = 2'b01; wb_rob_id[3:0] = id0; wb_data[31:0] = 32'h1234; rdy_in = 0; dec_valid = 1;
        h = head_rob_id; t = dec_rob_id; cv = commit_valid;
        repeat (3) begin
            step();
            checks++;
            if (head_rob_id !== h || dec_rob_id !== t || commit_valid !== cv) begin
                failures++;
                $display("FAIL rdy_hold: got head=%0d tail=%0d cv=%0b expected %0d %0d %0b",
                         head_rob_id, dec_rob_id, commit_valid, h, t, cv);
            end
        end
        rdy_in = 1; dec_valid = 0; step();
        set_idle(); step();
        checks++;
        if (commit_valid !== 1 || commit_rob_id !== id0 || commit_data !== 32'h1234) begin
            failures++;
            $display("FAIL rdy_resume: got cv=%0b id=%0d data=%h expected 1 %0d 1234", commit_valid, commit_rob_id, commit_data, id0);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            set_idle(); dec_valid = 1; dec_ready = 1; dec_res = 32'h55 + i; dec_dest = 5'd7; step();
        end
        rst_in = 1;
        #1;
        checks++;
        if (commit_valid !== 0 || rob_empty !== 1 || dec_rob_id !== 0 || head_rob_id !== 0 || flush !== 0) begin
            failures++;
            $display("FAIL async_reset: got cv=%0b empty=%0b tail=%0d head=%0d fl=%0b expected 0 1 0 0 0",
                     commit_valid, rob_empty, dec_rob_id, head_rob_id, flush);
        end
        model_reset();
        set_idle();
        @(negedge clk_in) rst_in = 0;
        @(posedge clk_in);
        #1;
        repeat (2) step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_idle();
            rdy_in = ($urandom_range(9) != 0);
            dec_valid = ($urandom_range(9) < 6);
            dec_type = 2'($urandom_range(2));
            dec_ready = ($urandom_range(9) < 3);
            dec_res = $urandom; dec_dest = 5'($urandom_range(31)); dec_predict = 1'($urandom_range(1));
            dec_next_addr = $urandom; dec_jump_addr = $urandom;
            for (int c = 0; c < 2; c++) begin
                wb_valid[c] = 1'($urandom_range(1));
                if (q.size() > 0 && $urandom_range(3) != 0)
                    wb_rob_id[c*4 +: 4] = q[$urandom_range(q.size() - 1)].id;
                else
                    wb_rob_id[c*4 +: 4] = 4'($urandom_range(15));
                wb_data[c*32 +: 32] = $urandom;
                wb_taken[c] = 1'($urandom_range(1));
            end
            if ($urandom_range(7) == 0) wb_rob_id[7:4] = wb_rob_id[3:0];
            qj_rob_id = 4'($urandom_range(15));
            qk_rob_id = (q.size() > 0) ? q[$urandom_range(q.size() - 1)].id : 4'($urandom_range(15));
            step();
        end
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_mispredict();
        test_forward();
        test_wrap();
        test_rdy_hold();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
